// File: rtl/exe_div_seq_if.sv
// EXE <-> divider handshake bundle: request, result, cancel and busy status.
interface exe_div_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  div_valid;
  logic                  div_ready;
  logic                  div_signed;
  logic [DATA_WIDTH-1:0] div_src1;
  logic [DATA_WIDTH-1:0] div_src2;
  logic                  cancel;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_quot;
  logic [DATA_WIDTH-1:0] out_rem;
  logic                  busy;

  modport master (
    output div_valid, div_signed, div_src1, div_src2, cancel, out_ready,
    input  div_ready, out_valid, out_quot, out_rem, busy
  );

  modport slave (
    input  div_valid, div_signed, div_src1, div_src2, cancel, out_ready,
    output div_ready, out_valid, out_quot, out_rem, busy
  );
endinterface

// File: rtl/exe_div_seq.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per cycle,
// sign fix-up in a final cycle, result held until EXE takes it.
module exe_div_seq #(
  parameter int DATA_WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  exe_div_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] divisor;
  logic [DATA_WIDTH-1:0] rem;
  logic [DATA_WIDTH-1:0] quot;
  logic [DATA_WIDTH-1:0] dividend_raw;
  logic [DATA_WIDTH-1:0] quot_res;
  logic [DATA_WIDTH-1:0] rem_res;
  logic                  quot_neg;
  logic                  rem_neg;
  logic                  div_zero;
  logic                  accept;
  logic                  load_res;
  logic                  last_step;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH:0]   trial;

  function automatic logic [DATA_WIDTH-1:0] abs_val(
    input logic signed [DATA_WIDTH-1:0] v,
    input logic                         is_signed
  );
    logic signed [DATA_WIDTH-1:0] neg;
    neg = -v;
    return (is_signed && v < 0) ? $unsigned(neg) : $unsigned(v);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] cond_neg(
    input logic [DATA_WIDTH-1:0] v,
    input logic                  en
  );
    return en ? (~v + 1'b1) : v;
  endfunction

  assign accept    = (state == IDLE) && bus.div_valid && !bus.cancel;
  assign load_res  = (state == FIX) && !bus.cancel;
  assign last_step = (cnt == CNT_W'(DATA_WIDTH - 1));

  // Restoring step: the shifted remainder needs one extra bit, since it can
  // reach 2*divisor-1 before the trial subtraction.
  assign rem_shift = {rem, quot[DATA_WIDTH-1]};
  assign trial     = rem_shift - {1'b0, divisor};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (accept)
        cnt <= '0;
      else if (state == CALC)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.div_valid && !bus.cancel) state_next = CALC;
      CALC: begin
        if (bus.cancel)     state_next = IDLE;
        else if (last_step) state_next = FIX;
      end
      FIX:  state_next = bus.cancel ? IDLE : DONE;
      DONE: if (bus.cancel || bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Working datapath: loaded on acceptance, stepped in CALC, otherwise held.
  always_ff @(posedge clk) begin
    if (accept) begin
      divisor      <= abs_val(bus.div_src2, bus.div_signed);
      quot         <= abs_val(bus.div_src1, bus.div_signed);
      rem          <= '0;
      quot_neg     <= bus.div_signed && (bus.div_src1[DATA_WIDTH-1] ^ bus.div_src2[DATA_WIDTH-1]);
      rem_neg      <= bus.div_signed && bus.div_src1[DATA_WIDTH-1];
      div_zero     <= (bus.div_src2 == '0);
      dividend_raw <= bus.div_src1;
    end else if (state == CALC) begin
      rem  <= trial[DATA_WIDTH] ? rem_shift[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
      quot <= {quot[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
    end
  end

  // Zero divisor bypasses the sign fix-up and reports all-ones / dividend.
  always_ff @(posedge clk) begin
    if (reset) begin
      quot_res <= '0;
      rem_res  <= '0;
    end else if (load_res) begin
      if (div_zero) begin
        quot_res <= '1;
        rem_res  <= dividend_raw;
      end else begin
        quot_res <= cond_neg(quot, quot_neg);
        rem_res  <= cond_neg(rem, rem_neg);
      end
    end
  end

  assign bus.div_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_quot  = quot_res;
  assign bus.out_rem   = rem_res;
endmodule

// File: tb/tb_exe_div_seq.sv
// Randomized and directed bench for exe_div_seq against a plain-arithmetic
// division reference.
module tb_exe_div_seq;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  exe_div_seq_if #(.DATA_WIDTH(32)) bus ();
  exe_div_seq #(.DATA_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Truncating division done in 64 bits so the signed overflow case wraps cleanly.
  function automatic void ref_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      return;
    end
    sa = s ? longint'({{32{a[31]}}, a}) : longint'({32'd0, a});
    sb = s ? longint'({{32{b[31]}}, b}) : longint'({32'd0, b});
    lq = sa / sb;
    lr = sa % sb;
    q = lq[31:0];
    r = lr[31:0];
  endfunction

  task automatic start(input bit s, input logic [31:0] a, input logic [31:0] b);
    int w = 0;
    while (!bus.div_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_before_req", bus.div_ready, 1'b1);
    bus.div_valid  = 1'b1;
    bus.div_signed = s;
    bus.div_src1   = a;
    bus.div_src2   = b;
    @(posedge clk); #1;
    bus.div_valid = 1'b0;
    bus.div_src1  = $urandom;
    bus.div_src2  = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (!bus.out_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk({tag, "_latency"}, cyc, 33);
    chk({tag, "_busy"}, bus.busy, 1'b1);
    chk({tag, "_ready_low"}, bus.div_ready, 1'b0);
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_ov_drop"}, bus.out_valid, 1'b0);
    chk({tag, "_ready_back"}, bus.div_ready, 1'b1);
  endtask

  task automatic run(input string tag, input bit s, input logic [31:0] a,
                     input logic [31:0] b, input int hold);
    logic [31:0] q, r;
    ref_div(s, a, b, q, r);
    start(s, a, b);
    wait_done(tag);
    chk({tag, "_quot"}, bus.out_quot, q);
    chk({tag, "_rem"}, bus.out_rem, r);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_ov"}, bus.out_valid, 1'b1);
      chk({tag, "_hold_q"}, bus.out_quot, q);
    end
    handshake(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b;
    bit s;
    reset          = 1'b1;
    bus.div_valid  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_src1   = '0;
    bus.div_src2   = '0;
    bus.cancel     = 1'b0;
    bus.out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", bus.div_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_ov", bus.out_valid, 1'b0);
    chk("rst_quot", bus.out_quot, 32'd0);
    chk("rst_rem", bus.out_rem, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run("u100_7", 1'b0, 32'd100, 32'd7, 0);
    run("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1);
    run("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 0);
    run("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 0);
    run("s_5_0", 1'b1, 32'd5, 32'd0, 0);
    run("u_5_0", 1'b0, 32'd5, 32'd0, 0);

    // Backpressure: DONE held, competing request must wait for the handshake.
    start(1'b0, 32'd50, 32'd8);
    wait_done("bp");
    bus.div_valid  = 1'b1;
    bus.div_signed = 1'b0;
    bus.div_src1   = 32'd9;
    bus.div_src2   = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_ov", bus.out_valid, 1'b1);
      chk("bp_quot", bus.out_quot, 32'd6);
      chk("bp_rem", bus.out_rem, 32'd2);
      chk("bp_ready", bus.div_ready, 1'b0);
    end
    handshake("bp");
    @(posedge clk); #1;
    bus.div_valid = 1'b0;
    chk("bp2_accepted", bus.busy, 1'b1);
    wait_done("bp2");
    chk("bp2_quot", bus.out_quot, 32'd3);
    chk("bp2_rem", bus.out_rem, 32'd0);
    handshake("bp2");

    // Cancel on the 10th CALC edge.
    start(1'b0, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk); #1;
      chk("cx_no_ov", bus.out_valid, 1'b0);
    end
    bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.cancel = 1'b0;
    chk("cx_ready", bus.div_ready, 1'b1);
    chk("cx_busy", bus.busy, 1'b0);
    chk("cx_ov", bus.out_valid, 1'b0);
    run("cx_20_6", 1'b0, 32'd20, 32'd6, 0);

    // Cancel in IDLE outranks a request.
    bus.cancel    = 1'b1;
    bus.div_valid = 1'b1;
    bus.div_src1  = 32'd4;
    bus.div_src2  = 32'd2;
    @(posedge clk); #1;
    bus.cancel    = 1'b0;
    bus.div_valid = 1'b0;
    chk("cx_idle_busy", bus.busy, 1'b0);

    // Reset after 17 CALC steps.
    start(1'b0, 32'd1000, 32'd3);
    repeat (17) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mr_busy", bus.busy, 1'b0);
    chk("mr_ov", bus.out_valid, 1'b0);
    chk("mr_quot", bus.out_quot, 32'd0);
    chk("mr_rem", bus.out_rem, 32'd0);
    chk("mr_ready", bus.div_ready, 1'b1);
    run("mr_1_1", 1'b0, 32'd1, 32'd1, 0);

    for (int i = 0; i < 30; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        4: b = -($urandom_range(1, 9));
        default: ;
      endcase
      run("rand", s, a, b, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
